// File: rtl/age_stage_multi.sv
// Age-update pipeline stage for the BLESS deflection router.
// Registers NUM_CH network flit control words plus one injection slot (index NUM_CH),
// ages every valid flit by AGE_STEP (saturating or wrapping), gates the injection slot
// with the arbiter grant, tracks the oldest valid slot and counts saturation events.
// Control word layout: bit CTRL_W-1 = valid, bits AGE_W-1:0 = age, other bits pass through.
module age_stage_multi #(
    parameter int NUM_CH      = 4,
    parameter int CTRL_W      = 24,
    parameter int AGE_W       = 8,
    parameter int AGE_STEP    = 1,
    parameter int SATURATE    = 1,
    parameter int AGE_STALLED = 0,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [NUM_CH*CTRL_W-1:0]       ch_ctrl_in,
    input  logic [CTRL_W-1:0]              inj_ctrl_in,
    input  logic                           inj_grant,
    output logic [(NUM_CH+1)*CTRL_W-1:0]   ch_ctrl_out,
    output logic                           inj_ack,
    output logic                           oldest_valid,
    output logic [$clog2(NUM_CH+1)-1:0]    oldest_idx,
    output logic [CNT_W-1:0]               sat_cnt
);

    localparam int SLOTS = NUM_CH + 1;
    localparam int IDX_W = $clog2(SLOTS);
    localparam int EV_W  = $clog2(SLOTS + 1);
    localparam int SUM_W = ((CNT_W > EV_W) ? CNT_W : EV_W) + 1;

    localparam logic [AGE_W:0]    C_STEP    = (AGE_W+1)'(AGE_STEP);
    localparam logic [AGE_W-1:0]  C_AGE_MAX = '1;
    localparam logic [SUM_W-1:0]  C_CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    // Registered state
    logic [SLOTS*CTRL_W-1:0] r_ctrl;
    logic                    r_inj_ack;
    logic                    r_oldest_valid;
    logic [IDX_W-1:0]        r_oldest_idx;
    logic [CNT_W-1:0]        r_sat_cnt;

    // Next-state values
    logic [SLOTS*CTRL_W-1:0] w_next_ctrl;
    logic                    w_inj_ack;
    logic                    w_oldest_valid;
    logic [IDX_W-1:0]        w_oldest_idx;
    logic [EV_W-1:0]         w_sat_events;
    logic [CTRL_W-1:0]       w_slot;
    logic [CTRL_W:0]         w_age_res;
    logic [AGE_W-1:0]        w_best_age;
    logic [SUM_W-1:0]        w_cnt_sum;
    logic [CNT_W-1:0]        w_cnt_next;

    // Applies the age rule to one valid word; returns {saturation_event, updated_word}.
    // The sum is one bit wider than the age field so the carry reveals an overflow.
    function automatic logic [CTRL_W:0] f_age(input logic [CTRL_W-1:0] word);
        logic [AGE_W:0]    sum;
        logic [CTRL_W-1:0] res;
        logic              ev;
        res = word;
        ev  = 1'b0;
        sum = {1'b0, word[AGE_W-1:0]} + C_STEP;
        if (sum[AGE_W] && (SATURATE != 0)) begin
            res[AGE_W-1:0] = C_AGE_MAX;
            ev             = 1'b1;
        end else begin
            res[AGE_W-1:0] = sum[AGE_W-1:0];
        end
        return {ev, res};
    endfunction

    // Next slot contents, injection ack, saturation events and oldest-slot selection.
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_next_ctrl    = r_ctrl;
        w_inj_ack      = 1'b0;
        w_sat_events   = '0;
        w_oldest_valid = 1'b0;
        w_oldest_idx   = '0;
        w_best_age     = '0;
        w_slot         = '0;
        w_age_res      = '0;

        // Capture new words unless stalled; a dropped injection keeps its other fields.
        if (!stall) begin
            w_next_ctrl = {inj_ctrl_in, ch_ctrl_in};
            w_next_ctrl[SLOTS*CTRL_W-1] = inj_ctrl_in[CTRL_W-1] & inj_grant;
            w_inj_ack   = inj_ctrl_in[CTRL_W-1] & inj_grant;
        end

        // Age valid slots on capture, and in place while stalled if enabled.
        if (!stall || (AGE_STALLED != 0)) begin
            for (int s = 0; s < SLOTS; s++) begin
                w_slot = w_next_ctrl[s*CTRL_W +: CTRL_W];
                if (w_slot[CTRL_W-1]) begin
                    w_age_res = f_age(w_slot);
                    w_next_ctrl[s*CTRL_W +: CTRL_W] = w_age_res[CTRL_W-1:0];
                    w_sat_events = w_sat_events + EV_W'(w_age_res[CTRL_W]);
                end
            end
        end

        // Oldest valid slot of the next state; strict compare keeps ties on the lowest index.
        for (int s = 0; s < SLOTS; s++) begin
            w_slot = w_next_ctrl[s*CTRL_W +: CTRL_W];
            if (w_slot[CTRL_W-1] && (!w_oldest_valid || (w_slot[AGE_W-1:0] > w_best_age))) begin
                w_oldest_valid = 1'b1;
                w_oldest_idx   = IDX_W'(s);
                w_best_age     = w_slot[AGE_W-1:0];
            end
        end
    end

    // Saturation counter update, clamped at its maximum instead of wrapping.
    always_comb begin
        w_cnt_sum  = SUM_W'(r_sat_cnt) + SUM_W'(w_sat_events);
        w_cnt_next = (w_cnt_sum > C_CNT_MAX) ? CNT_W'(C_CNT_MAX) : w_cnt_sum[CNT_W-1:0];
    end

    // State registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl         <= '0;
            r_inj_ack      <= 1'b0;
            r_oldest_valid <= 1'b0;
            r_oldest_idx   <= '0;
            r_sat_cnt      <= '0;
        end else begin
            r_ctrl         <= w_next_ctrl;
            r_inj_ack      <= w_inj_ack;
            r_oldest_valid <= w_oldest_valid;
            r_oldest_idx   <= w_oldest_idx;
            r_sat_cnt      <= w_cnt_next;
        end
    end

    assign ch_ctrl_out  = r_ctrl;
    assign inj_ack      = r_inj_ack;
    assign oldest_valid = r_oldest_valid;
    assign oldest_idx   = r_oldest_idx;
    assign sat_cnt      = r_sat_cnt;

endmodule

// File: tb/tb_age_stage_multi.sv
// Directed bench for age_stage_multi: four instances with different parameter sets share
// one stimulus stream (defaults, wrapping ages, ageing while stalled, 2-bit counter).
module tb_age_stage_multi;

    localparam int NUM_CH = 4;
    localparam int CTRL_W = 24;
    localparam int SLOTS  = NUM_CH + 1;

    logic                     clk;
    logic                     rst_n;
    logic                     stall;
    logic [NUM_CH*CTRL_W-1:0] ch_ctrl_in;
    logic [CTRL_W-1:0]        inj_ctrl_in;
    logic                     inj_grant;

    logic [SLOTS*CTRL_W-1:0]  d_out, w_out, s_out, c_out;
    logic                     d_ack, w_ack, s_ack, c_ack;
    logic                     d_ov,  w_ov,  s_ov,  c_ov;
    logic [2:0]               d_idx, w_idx, s_idx, c_idx;
    logic [15:0]              d_cnt, w_cnt, s_cnt;
    logic [1:0]               c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    age_stage_multi u_def (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ch_ctrl_in(ch_ctrl_in),
        .inj_ctrl_in(inj_ctrl_in), .inj_grant(inj_grant), .ch_ctrl_out(d_out),
        .inj_ack(d_ack), .oldest_valid(d_ov), .oldest_idx(d_idx), .sat_cnt(d_cnt));

    age_stage_multi #(.SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ch_ctrl_in(ch_ctrl_in),
        .inj_ctrl_in(inj_ctrl_in), .inj_grant(inj_grant), .ch_ctrl_out(w_out),
        .inj_ack(w_ack), .oldest_valid(w_ov), .oldest_idx(w_idx), .sat_cnt(w_cnt));

    age_stage_multi #(.AGE_STALLED(1)) u_agst (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ch_ctrl_in(ch_ctrl_in),
        .inj_ctrl_in(inj_ctrl_in), .inj_grant(inj_grant), .ch_ctrl_out(s_out),
        .inj_ack(s_ack), .oldest_valid(s_ov), .oldest_idx(s_idx), .sat_cnt(s_cnt));

    age_stage_multi #(.CNT_W(2)) u_clmp (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ch_ctrl_in(ch_ctrl_in),
        .inj_ctrl_in(inj_ctrl_in), .inj_grant(inj_grant), .ch_ctrl_out(c_out),
        .inj_ack(c_ack), .oldest_valid(c_ov), .oldest_idx(c_idx), .sat_cnt(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    function automatic logic [CTRL_W-1:0] mk(input logic v, input logic [14:0] mid,
                                             input logic [7:0] age);
        return {v, mid, age};
    endfunction

    function automatic logic [SLOTS*CTRL_W-1:0] pack5(input logic [CTRL_W-1:0] s0, s1, s2, s3, s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CTRL_W-1:0] c0, c1, c2, c3, inj, input logic g, st);
        ch_ctrl_in  = {c3, c2, c1, c0};
        inj_ctrl_in = inj;
        inj_grant   = g;
        stall       = st;
    endtask

    localparam logic [CTRL_W-1:0] Z = '0;

    initial begin
        rst_n = 1'b0;
        drive(Z, Z, Z, Z, Z, 1'b0, 1'b0);
        #12;
        check("reset_out",  d_out, '0);
        check("reset_ack",  d_ack, 1'b0);
        check("reset_ov",   d_ov,  1'b0);
        check("reset_idx",  d_idx, 3'd0);
        check("reset_cnt",  d_cnt, 16'd0);
        rst_n = 1'b1;

        // Pass-through with default parameters.
        @(negedge clk);
        drive(mk(1, 15'h1234, 8'd5), mk(0, 15'h0aaa, 8'd33), mk(1, 15'h7001, 8'd9),
              mk(0, 15'h0055, 8'd77), Z, 1'b0, 1'b0);
        step();
        check("pass_out", d_out, pack5(mk(1, 15'h1234, 8'd6), mk(0, 15'h0aaa, 8'd33),
                                       mk(1, 15'h7001, 8'd10), mk(0, 15'h0055, 8'd77), Z));
        check("pass_idx", d_idx, 3'd2);
        check("pass_ov",  d_ov,  1'b1);
        check("pass_ack", d_ack, 1'b0);

        // Saturation versus wrap.
        drive(Z, mk(1, 15'h0101, 8'd255), Z, Z, Z, 1'b0, 1'b0);
        step();
        check("sat_out",   d_out, pack5(Z, mk(1, 15'h0101, 8'd255), Z, Z, Z));
        check("sat_cnt",   d_cnt, 16'd1);
        check("sat_idx",   d_idx, 3'd1);
        check("wrap_out",  w_out, pack5(Z, mk(1, 15'h0101, 8'd0), Z, Z, Z));
        check("wrap_cnt",  w_cnt, 16'd0);
        check("clmp_cnt1", c_cnt, 2'd1);

        // Injection without grant: dropped, other fields still pass.
        drive(Z, Z, Z, Z, mk(1, 15'h2222, 8'd3), 1'b0, 1'b0);
        step();
        check("nogrant_out", d_out, pack5(Z, Z, Z, Z, mk(0, 15'h2222, 8'd3)));
        check("nogrant_ack", d_ack, 1'b0);
        check("nogrant_ov",  d_ov,  1'b0);
        check("nogrant_idx", d_idx, 3'd0);

        // Injection with grant, then ack must drop again.
        inj_grant = 1'b1;
        step();
        check("grant_out", d_out, pack5(Z, Z, Z, Z, mk(1, 15'h2222, 8'd4)));
        check("grant_ack", d_ack, 1'b1);
        check("grant_idx", d_idx, 3'd4);
        drive(Z, Z, Z, Z, Z, 1'b0, 1'b0);
        step();
        check("ack_pulse", d_ack, 1'b0);

        // Stall: load ch3 age 7, then stall 3 cycles with conflicting inputs and a grant.
        drive(Z, Z, Z, mk(1, 15'h3333, 8'd7), Z, 1'b0, 1'b0);
        step();
        check("load_out", d_out, pack5(Z, Z, Z, mk(1, 15'h3333, 8'd8), Z));
        drive(mk(1, 15'h4444, 8'd100), Z, Z, Z, mk(1, 15'h5555, 8'd1), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold",   d_out, pack5(Z, Z, Z, mk(1, 15'h3333, 8'd8), Z));
            check("stall_age",    s_out, pack5(Z, Z, Z, mk(1, 15'h3333, 8'(9 + i)), Z));
            check("stall_ack",    d_ack, 1'b0);
            check("stall_ack_ag", s_ack, 1'b0);
            check("stall_idx",    s_idx, 3'd3);
        end

        // Tie between ch0 and ch3 goes to the lower index.
        drive(mk(1, 15'h0001, 8'd20), Z, Z, mk(1, 15'h0003, 8'd20), Z, 1'b0, 1'b0);
        step();
        check("tie_idx", d_idx, 3'd0);
        check("tie_out", d_out, pack5(mk(1, 15'h0001, 8'd21), Z, Z, mk(1, 15'h0003, 8'd21), Z));

        // Five saturating slots in one cycle; 2-bit counter clamps at 3.
        drive(mk(1, 15'h0, 8'd255), mk(1, 15'h0, 8'd255), mk(1, 15'h0, 8'd255),
              mk(1, 15'h0, 8'd255), mk(1, 15'h0, 8'd255), 1'b1, 1'b0);
        step();
        check("multi_cnt",  d_cnt, 16'd6);
        check("clamp_cnt",  c_cnt, 2'd3);
        check("multi_idx",  d_idx, 3'd0);
        check("multi_ack",  d_ack, 1'b1);
        step();
        check("multi_cnt2", d_cnt, 16'd11);
        check("clamp_hold", c_cnt, 2'd3);

        // Reset mid-traffic, between edges: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", d_out, '0);
        check("mid_rst_ack", d_ack, 1'b0);
        check("mid_rst_ov",  d_ov,  1'b0);
        check("mid_rst_idx", d_idx, 3'd0);
        check("mid_rst_cnt", d_cnt, 16'd0);
        check("mid_rst_clm", c_cnt, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
